sccb_responder: RTL and testbench
=================================

SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 SHALL have parameter DEV_ID, default 7'h21, meaning the 7-bit SCCB slave ID (write byte 0x42, read byte 0x43).
REQ-002 SHALL have port PCLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port PRESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port sioc_in, input, 1 bit: SCCB clock from the initiator (asynchronous to PCLK).
REQ-005 SHALL have port siod_in, input, 1 bit: SCCB data line as read at the pad.
REQ-006 SHALL have port siod_oe, output, 1 bit: 1 means the pad pulls SIOD low (open-drain); 0 means released.
REQ-007 SHALL have port reg_addr, output, 8 bits: latched sub-address.
REQ-008 SHALL have port reg_wdata, output, 8 bits: received write data.
REQ-009 SHALL have port reg_we, output, 1 bit: one-PCLK write strobe.
REQ-010 SHALL have port reg_re, output, 1 bit: one-PCLK read-request strobe.
REQ-011 SHALL have port reg_rdata, input, 8 bits: register read data, sampled on the PCLK edge after reg_re.
REQ-012 SHALL have port busy, output, 1 bit: high from START detection until STOP or abort.

Function
REQ-013 SHALL pass sioc_in and siod_in through 2-flop synchronizers and derive rise/fall events from the synchronized values; the PCLK frequency is at least 8x the SIOC frequency.
REQ-014 SHALL detect START as synchronized SIOD falling while SIOC is high, and STOP as SIOD rising while SIOC is high, in any state.
REQ-015 SHALL sample SIOD MSB-first on each SIOC rising edge and change siod_oe only on the PCLK after an SIOC falling edge.
REQ-016 SHALL implement the states IDLE, ID, ID_X, SUB, SUB_X, WDATA, WD_X, RDATA, RD_NA and WAIT_STOP.
REQ-017 In ID, after 8 bits: if bits[7:1] != DEV_ID, go to WAIT_STOP and never drive; if it matches, go to ID_X, with bit0=0 meaning write and bit0=1 meaning read.
REQ-018 After ID_X: a write transaction goes to SUB, then SUB_X; a read transaction pulses reg_re, loads reg_rdata into the shift register, and goes to RDATA.
REQ-019 SUB SHALL update reg_addr at the end of the 8th bit; the address is retained across transactions for a later 2-phase read.
REQ-020 After SUB_X, WDATA SHALL receive 8 bits, set reg_wdata and pulse reg_we for exactly 1 PCLK on the 8th SIOC rise, then go to WD_X and then WAIT_STOP.
REQ-021 RDATA SHALL drive siod_oe = ~bit MSB-first for 8 bits, then release in RD_NA (NA bit ignored), then go to WAIT_STOP.
REQ-022 WAIT_STOP SHALL keep siod_oe = 0 and ignore bits; further data bytes produce no additional reg_we.
REQ-023 A STOP in any state SHALL go to IDLE with siod_oe = 0; a partial byte produces no strobe.
REQ-024 A START in any non-IDLE state (repeated start) SHALL restart at ID with the bit counter cleared.
REQ-025 reg_we and reg_re SHALL never be asserted together.

Reset
REQ-026 While PRESET is high: state = IDLE, siod_oe = 0, reg_we = 0, reg_re = 0, busy = 0, reg_addr = 0, reg_wdata = 0, synchronizers = 1.
REQ-027 Reset asserted mid-transaction SHALL release SIOD immediately (asynchronously); after release, the block waits for a fresh START.

Configuration
REQ-028 With macro SCCB_RESP_ACK_EN defined, the block SHALL drive siod_oe = 1 during ID_X, SUB_X and WD_X (I2C-style ACK).
REQ-029 Without SCCB_RESP_ACK_EN, siod_oe SHALL stay 0 during those don't-care bits (pure SCCB).

Verification
REQ-030 Write START, 0x42, X, 0x12, X, 0x80, X, STOP -> exactly one reg_we with reg_addr = 0x12 and reg_wdata = 0x80; busy falls after STOP.
REQ-031 Write START, 0x42, 0x0A, STOP, then START, 0x43, with reg_rdata = 0x76 -> one reg_re with reg_addr = 0x0A; siod_oe over 8 bits = 1,0,0,0,1,0,0,1; released at the NA bit.
REQ-032 Write START, 0x60, ... -> no strobes and siod_oe = 0 throughout (also with SCCB_RESP_ACK_EN).
REQ-033 Write STOP after 5 bits of the data byte -> no reg_we and state = IDLE; a following valid write succeeds.
REQ-034 Assert PRESET during RDATA bit 3 -> siod_oe = 0 within the same cycle and all strobes low.
REQ-035 With SCCB_RESP_ACK_EN, write 0x42, 0x12, 0x80 -> siod_oe = 1 on each of the three 9th bits; without the macro it stays 0.

Source files
------------

// File: rtl/sccb_responder.sv
// SCCB register-access responder: decodes ID / sub-address / data bytes and drives read data open-drain.
// Define SCCB_RESP_ACK_EN to pull SIOD low on the 9th bit of ID, sub-address and write-data bytes.
module sccb_responder #(
    parameter logic [6:0] DEV_ID = 7'h21
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

`ifdef SCCB_RESP_ACK_EN
    localparam logic ACK_DRIVE = 1'b1;
`else
    localparam logic ACK_DRIVE = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ID, ID_X, SUB, SUB_X, WDATA, WD_X, RDATA, RD_NA, WAIT_STOP
    } state_t;

    state_t     state, state_next;
    logic       sioc_s1, sioc_s2, sioc_q;
    logic       siod_s1, siod_s2, siod_q;
    logic       sioc_rise, sioc_fall, start_ev, stop_ev;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] rx_byte;
    logic       rd_op;
    logic       last_bit;
    logic       x_state;
    logic       oe_next;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sioc_s1 <= 1'b1;
            sioc_s2 <= 1'b1;
            sioc_q  <= 1'b1;
            siod_s1 <= 1'b1;
            siod_s2 <= 1'b1;
            siod_q  <= 1'b1;
        end else begin
            sioc_s1 <= sioc_in;
            sioc_s2 <= sioc_s1;
            sioc_q  <= sioc_s2;
            siod_s1 <= siod_in;
            siod_s2 <= siod_s1;
            siod_q  <= siod_s2;
        end
    end

    assign sioc_rise = sioc_s2 & ~sioc_q;
    assign sioc_fall = ~sioc_s2 & sioc_q;
    assign start_ev  = sioc_s2 & sioc_q & siod_q & ~siod_s2;
    assign stop_ev   = sioc_s2 & sioc_q & ~siod_q & siod_s2;
    // Byte including the bit being sampled on this SIOC rise.
    assign rx_byte   = {shreg[6:0], siod_s2};
    assign last_bit  = sioc_rise && (bit_cnt == 3'd7);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (stop_ev) begin
            state_next = IDLE;
        end else if (start_ev) begin
            state_next = ID;
        end else if (sioc_rise) begin
            case (state)
                ID:    if (last_bit) state_next = (rx_byte[7:1] == DEV_ID) ? ID_X : WAIT_STOP;
                ID_X:  state_next = rd_op ? RDATA : SUB;
                SUB:   if (last_bit) state_next = SUB_X;
                SUB_X: state_next = WDATA;
                WDATA: if (last_bit) state_next = WD_X;
                WD_X:  state_next = WAIT_STOP;
                RDATA: if (last_bit) state_next = RD_NA;
                RD_NA: state_next = WAIT_STOP;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        x_state = (state == ID_X) || (state == SUB_X) || (state == WD_X);
        case (state)
            ID_X, SUB_X, WD_X: oe_next = ACK_DRIVE;
            RDATA:             oe_next = ~shreg[7];
            default:           oe_next = 1'b0;
        endcase
    end

    // Byte-level datapath; the read byte is loaded on the cycle after reg_re and then shifts out on SIOC rises.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            rd_op     <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            siod_oe   <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            if (reg_re)         shreg <= reg_rdata;
            else if (sioc_rise) shreg <= rx_byte;
            if (start_ev || stop_ev) begin
                bit_cnt <= 3'd0;
                siod_oe <= 1'b0;
            end else begin
                if (sioc_rise && !x_state && (state != IDLE)) bit_cnt <= bit_cnt + 3'd1;
                if (sioc_fall) siod_oe <= oe_next;
                if ((state == ID) && last_bit) rd_op <= rx_byte[0];
                if ((state == SUB) && last_bit) reg_addr <= rx_byte;
                if ((state == WDATA) && last_bit) begin
                    reg_wdata <= rx_byte;
                    reg_we    <= 1'b1;
                end
                if ((state == ID_X) && sioc_rise && rd_op) reg_re <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: directed SCCB transactions followed by randomized ones,
// checked against a transaction-level model of register address/data and per-bit SIOD drive.
module tb_sccb_responder;

`ifdef SCCB_RESP_ACK_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif
    localparam logic [6:0] DEV = 7'h21;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       siod_pad;
    logic       siod_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    int vectors = 0;
    int miscompares = 0;
    int we_cnt = 0, re_cnt = 0, both_cnt = 0;
    logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00;
    logic [7:0] model_addr = 8'h00, model_wdata = 8'h00;

    assign siod_pad = sda_m & ~siod_oe;

    sccb_responder #(.DEV_ID(DEV)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .sioc_in(scl_m), .siod_in(siod_pad),
        .siod_oe(siod_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    // Strobe monitor: counts PCLK cycles each strobe is high and captures the bus at that moment.
    always @(negedge PCLK) begin
        if (reg_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = reg_addr;
            we_data = reg_wdata;
        end
        if (reg_re) begin
            re_cnt  = re_cnt + 1;
            re_addr = reg_addr;
        end
        if (reg_we && reg_re) both_cnt = both_cnt + 1;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic sendStart();
        sda_m = 1'b1; waitClk(3);
        scl_m = 1'b1; waitClk(4);
        sda_m = 1'b0; waitClk(4);
        scl_m = 1'b0; waitClk(3);
    endtask

    task automatic sendStop();
        sda_m = 1'b0; waitClk(3);
        scl_m = 1'b1; waitClk(4);
        sda_m = 1'b1; waitClk(4);
    endtask

    task automatic sendBit(input logic v, output logic oe);
        sda_m = v; waitClk(4);
        scl_m = 1'b1; waitClk(2);
        oe = siod_oe; waitClk(2);
        scl_m = 1'b0; waitClk(2);
    endtask

    // oe_seen[8:1] = responder drive on data bits MSB-first, oe_seen[0] = drive on the 9th bit.
    task automatic xferByte(input logic [7:0] b, output logic [8:0] oe_seen);
        logic o;
        for (int i = 0; i < 8; i++) begin
            sendBit(b[7-i], o);
            oe_seen[8-i] = o;
        end
        sendBit(1'b1, o);
        oe_seen[0] = o;
    endtask

    // One complete transaction from START (or repeated START) to STOP, with expectations from the model.
    task automatic applyStimulus(input string tag, input logic [7:0] id, input logic [7:0] sub,
                                 input logic [7:0] data, input int nbytes, input logic [7:0] rdata);
        logic [8:0] oe;
        logic [7:0] wbytes [3];
        logic       match;
        int         we0, re0, exp_we, exp_re;
        match = (id[7:1] == DEV);
        wbytes[0] = sub; wbytes[1] = data; wbytes[2] = 8'hA5;
        we0 = we_cnt; re0 = re_cnt; exp_we = 0; exp_re = 0;
        reg_rdata = rdata;
        sendStart();
        checkOutput({tag, "_busy"}, busy, 1);
        xferByte(id, oe);
        checkOutput({tag, "_id_oe"}, oe, {8'h00, match ? ACK : 1'b0});
        if (!match) begin
            for (int k = 0; k < nbytes; k++) begin
                xferByte(wbytes[k], oe);
                checkOutput({tag, "_nomatch_oe"}, oe, 0);
            end
        end else if (!id[0]) begin
            for (int k = 0; k < nbytes; k++) begin
                xferByte(wbytes[k], oe);
                checkOutput({tag, "_w_oe"}, oe, {8'h00, (k < 2) ? ACK : 1'b0});
            end
            if (nbytes >= 1) model_addr = sub;
            if (nbytes >= 2) begin
                model_wdata = data;
                exp_we = 1;
            end
        end else begin
            xferByte(8'hFF, oe);
            checkOutput({tag, "_rd_oe"}, oe, {~rdata, 1'b0});
            exp_re = 1;
        end
        sendStop();
        checkOutput({tag, "_we_count"}, we_cnt - we0, exp_we);
        checkOutput({tag, "_re_count"}, re_cnt - re0, exp_re);
        checkOutput({tag, "_addr"}, reg_addr, model_addr);
        checkOutput({tag, "_wdata"}, reg_wdata, model_wdata);
        checkOutput({tag, "_idle"}, busy, 0);
        if (exp_we == 1) begin
            checkOutput({tag, "_we_addr"}, we_addr, model_addr);
            checkOutput({tag, "_we_data"}, we_data, model_wdata);
        end
        if (exp_re == 1) checkOutput({tag, "_re_addr"}, re_addr, model_addr);
    endtask

    initial begin
        logic [8:0] oe;
        logic       o;
        logic [7:0] id, sub, data, rdata;
        int         kind, nb, we0, re0;

        reg_rdata = 8'h00;
        PRESET = 1'b1;
        waitClk(5);
        checkOutput("rst_oe", siod_oe, 0);
        checkOutput("rst_we", reg_we, 0);
        checkOutput("rst_re", reg_re, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_addr", reg_addr, 0);
        checkOutput("rst_wdata", reg_wdata, 0);
        PRESET = 1'b0;
        waitClk(5);

        applyStimulus("wr_basic", 8'h42, 8'h12, 8'h80, 2, 8'h00);
        applyStimulus("wr_addr", 8'h42, 8'h0A, 8'h00, 1, 8'h00);
        applyStimulus("rd_basic", 8'h43, 8'h00, 8'h00, 0, 8'h76);
        applyStimulus("bad_id", 8'h60, 8'h12, 8'h80, 3, 8'h00);
        applyStimulus("extra_byte", 8'h42, 8'h12, 8'h80, 3, 8'h00);

        // STOP after 5 bits of the data byte: address taken, no write strobe.
        we0 = we_cnt;
        sendStart();
        xferByte(8'h42, oe);
        xferByte(8'h33, oe);
        for (int i = 0; i < 5; i++) sendBit(1'b1, o);
        sendStop();
        model_addr = 8'h33;
        checkOutput("partial_we", we_cnt - we0, 0);
        checkOutput("partial_idle", busy, 0);
        checkOutput("partial_addr", reg_addr, model_addr);
        applyStimulus("after_partial", 8'h42, 8'h44, 8'h55, 2, 8'h00);

        // Repeated START after a 2-phase address write, then a read.
        sendStart();
        xferByte(8'h42, oe);
        xferByte(8'h20, oe);
        model_addr = 8'h20;
        applyStimulus("rs_read", 8'h43, 8'h00, 8'h00, 0, 8'hC3);

        // Repeated START in the middle of a byte restarts bit counting.
        sendStart();
        xferByte(8'h42, oe);
        for (int i = 0; i < 3; i++) sendBit(1'b1, o);
        applyStimulus("rs_mid", 8'h42, 8'h5C, 8'h3E, 2, 8'h00);

        // Reset during bit 3 of read data: all-zero data keeps the responder pulling SIOD low.
        re0 = re_cnt;
        reg_rdata = 8'h00;
        sendStart();
        xferByte(8'h43, oe);
        for (int i = 0; i < 3; i++) sendBit(1'b1, o);
        sda_m = 1'b1; waitClk(4);
        scl_m = 1'b1; waitClk(2);
        checkOutput("rd_bit3_drive", siod_oe, 1);
        #1 PRESET = 1'b1;
        #1;
        checkOutput("rstmid_oe", siod_oe, 0);
        checkOutput("rstmid_we", reg_we, 0);
        checkOutput("rstmid_re", reg_re, 0);
        checkOutput("rstmid_busy", busy, 0);
        waitClk(3);
        PRESET = 1'b0;
        model_addr = 8'h00;
        model_wdata = 8'h00;
        checkOutput("rstmid_re_count", re_cnt - re0, 1);
        checkOutput("rstmid_addr", reg_addr, 0);
        waitClk(2);
        scl_m = 1'b0; waitClk(3);
        sendStop();
        applyStimulus("after_reset", 8'h42, 8'h7E, 8'h19, 2, 8'h00);

        for (int t = 0; t < 16; t++) begin
            kind  = $urandom_range(0, 3);
            sub   = 8'($urandom);
            data  = 8'($urandom);
            rdata = 8'($urandom);
            nb    = $urandom_range(1, 3);
            case (kind)
                0: id = 8'h42;
                1: id = 8'h43;
                2: begin
                    id = 8'h42;
                    nb = 2;
                end
                default: begin
                    id = 8'($urandom);
                    if (id[7:1] == DEV) id = id ^ 8'h80;
                end
            endcase
            applyStimulus("rand", id, sub, data, nb, rdata);
        end

        checkOutput("we_re_exclusive", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
